// File: rtl/display_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared types and constants for the score display path: the converter state
// encoding, the largest displayable value, the blank anode pattern and the
// double-dabble nibble correction.
// -----------------------------------------------------------------------------
package display_pkg;

   // Converter sequence: wait for a request, shift VALUE_W times, then publish.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } conv_state_t;

   // Four decimal digits cannot show more than this.
   localparam int unsigned MAX_VALUE = 9999;

   // All anodes released (active-low), used for a blanked slot.
   localparam logic [3:0] AN_OFF = 4'b1111;

   // Double-dabble correction: a nibble of 5 or more would overflow past 9
   // after the next doubling, so it is pre-biased by 3 to carry correctly.
   function automatic logic [3:0] add3_adjust(input logic [3:0] nibble);
      return (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;
   endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl_if
// Request/display bundle between the score producer and the display scanner.
//   VALUE  producer -> scanner  binary score
//   LOAD   producer -> scanner  one-cycle convert request
//   BUSY   scanner  -> producer conversion in progress
//   DONE   scanner  -> producer one-cycle pulse when new digits are committed
//   BCD    scanner  -> panel    digit code of the scanned slot
//   AN     scanner  -> panel    active-low anode enables
// The producer side uses modport master, the scanner uses modport slave.
// -----------------------------------------------------------------------------
interface display_scan_ctrl_if #(
   parameter int VALUE_W = 14
);

   logic [VALUE_W-1:0] VALUE;
   logic               LOAD;
   logic               BUSY;
   logic               DONE;
   logic [3:0]         BCD;
   logic [3:0]         AN;

   modport master (
      output VALUE,
      output LOAD,
      input  BUSY,
      input  DONE,
      input  BCD,
      input  AN
   );

   modport slave (
      input  VALUE,
      input  LOAD,
      output BUSY,
      output DONE,
      output BCD,
      output AN
   );

endinterface

// File: rtl/display_scan_ctrl_bin2bcd.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter. A LOAD in IDLE captures the saturated
// value, VALUE_W shift cycles build the BCD result, and a single COMMIT cycle
// presents it with o_done high.
//   i_clk    system clock, rising edge
//   i_rst_n  synchronous active-low reset
//   i_value  binary input, clamped to MAX_VALUE
//   i_load   convert request, honoured only in IDLE
//   o_busy   high in SHIFT and COMMIT
//   o_done   high during the COMMIT cycle
//   o_bcd    four BCD nibbles, thousands in [15:12]
// -----------------------------------------------------------------------------
module bin2bcd_seq
   import display_pkg::*;
#(
   parameter int VALUE_W = 14
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [VALUE_W-1:0] i_value,
   input  logic               i_load,
   output logic               o_busy,
   output logic               o_done,
   output logic [15:0]        o_bcd
);

   localparam int STEP_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(VALUE_W - 1);

   conv_state_t        r_state;
   conv_state_t        w_state_next;
   logic [VALUE_W-1:0] r_bin;
   logic [VALUE_W-1:0] w_sat;
   logic [15:0]        r_acc;
   logic [15:0]        w_acc_adj;
   logic [STEP_W-1:0]  r_step;

   // ---- state register ------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every register sees
   // the pre-edge values of the others; reset is tested inside the clocked
   // block, making it synchronous.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---- next-state logic ----------------------------------------------------
   // NOTE: every combinational output is given a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (i_load) w_state_next = SHIFT;
         SHIFT:   if (r_step == LAST_STEP) w_state_next = COMMIT;
         COMMIT:  w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // ---- state outputs -------------------------------------------------------
   always_comb begin
      o_busy = 1'b0;
      o_done = 1'b0;
      case (r_state)
         SHIFT: begin
            o_busy = 1'b1;
         end
         COMMIT: begin
            o_busy = 1'b1;
            o_done = 1'b1;
         end
         default: begin
            o_busy = 1'b0;
            o_done = 1'b0;
         end
      endcase
   end

   // ---- datapath ------------------------------------------------------------
   // Anything above four digits is shown as 9999 rather than wrapping.
   always_comb begin
      if (32'(i_value) > MAX_VALUE) begin
         w_sat = VALUE_W'(MAX_VALUE);
      end else begin
         w_sat = i_value;
      end
   end

   // Correction is applied to the current accumulator and the shifted result
   // is stored, so add and shift complete within one cycle.
   always_comb begin
      w_acc_adj = {add3_adjust(r_acc[15:12]), add3_adjust(r_acc[11:8]),
                   add3_adjust(r_acc[7:4]),   add3_adjust(r_acc[3:0])};
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_bin  <= '0;
         r_acc  <= '0;
         r_step <= '0;
      end else if (r_state == IDLE) begin
         if (i_load) begin
            r_bin  <= w_sat;
            r_acc  <= '0;
            r_step <= '0;
         end
      end else if (r_state == SHIFT) begin
         // {acc,bin} shifts left as one register: the binary MSB enters the
         // units nibble.
         r_acc  <= {w_acc_adj[14:0], r_bin[VALUE_W-1]};
         r_bin  <= r_bin << 1;
         r_step <= r_step + 1'b1;
      end
   end

   assign o_bcd = r_acc;

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Feeds a 4-digit seven-segment decoder: converts a binary score to BCD and
// time-multiplexes the digits, blanking leading zeros by releasing the anode.
//   CLK    system clock, rising edge
//   RST_N  synchronous active-low reset
//   bus    display_scan_ctrl_if.slave: VALUE/LOAD in, BUSY/DONE/BCD/AN out
// Parameters: CLK_HZ, REFRESH_HZ (DIV = CLK_HZ/REFRESH_HZ clocks per digit,
// DIV >= 2), VALUE_W, LZ_BLANK (1 = blank leading zeros, units never blank).
// -----------------------------------------------------------------------------
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int REFRESH_HZ = 1000,
   parameter int VALUE_W    = 14,
   parameter bit LZ_BLANK   = 1'b1
) (
   input  logic               CLK,
   input  logic               RST_N,
   display_scan_ctrl_if.slave bus
);

   localparam int DIV   = CLK_HZ / REFRESH_HZ;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(DIV - 1);

   logic              w_busy;
   logic              w_done;
   logic [15:0]       w_bcd;

   logic [3:0][3:0]   r_digits;   // [0] = units ... [3] = thousands
   logic [CNT_W-1:0]  r_tick;
   logic [1:0]        r_idx;
   logic [3:0]        r_bcd;
   logic [3:0]        r_an;

   logic              w_wrap;
   logic [1:0]        w_idx_next;
   logic [3:0]        w_lz;       // [k] = digit k and all higher digits are 0
   logic [3:0]        w_an_next;

   // ---- converter -----------------------------------------------------------
   bin2bcd_seq #(
      .VALUE_W (VALUE_W)
   ) u_bin2bcd (
      .i_clk   (CLK),
      .i_rst_n (RST_N),
      .i_value (bus.VALUE),
      .i_load  (bus.LOAD),
      .o_busy  (w_busy),
      .o_done  (w_done),
      .o_bcd   (w_bcd)
   );

   // The panel keeps showing the previous digits until the converter commits.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_digits <= '0;
      end else if (w_done) begin
         r_digits <= w_bcd;
      end
   end

   // ---- scan divider and slot selection -------------------------------------
   assign w_wrap     = (r_tick == LAST_TICK);
   assign w_idx_next = r_idx + 2'd1;

   always_comb begin
      w_lz[3] = (r_digits[3] == 4'd0);
      w_lz[2] = w_lz[3] && (r_digits[2] == 4'd0);
      w_lz[1] = w_lz[2] && (r_digits[1] == 4'd0);
      w_lz[0] = w_lz[1] && (r_digits[0] == 4'd0);
   end

   // The units slot stays lit even for a zero score so the panel reads "0".
   always_comb begin
      if (LZ_BLANK && (w_idx_next != 2'd0) && w_lz[w_idx_next]) begin
         w_an_next = AN_OFF;
      end else begin
         w_an_next = ~(4'b0001 << w_idx_next);
      end
   end

   // BCD and AN are registered on the same edge that moves the slot index, so
   // the panel never sees a digit paired with the wrong anode.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_tick <= '0;
         r_idx  <= 2'd0;
         r_bcd  <= 4'd0;
         r_an   <= 4'b1110;
      end else if (w_wrap) begin
         r_tick <= '0;
         r_idx  <= w_idx_next;
         r_bcd  <= r_digits[w_idx_next];
         r_an   <= w_an_next;
      end else begin
         r_tick <= r_tick + 1'b1;
      end
   end

   assign bus.BUSY = w_busy;
   assign bus.DONE = w_done;
   assign bus.BCD  = r_bcd;
   assign bus.AN   = r_an;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
// Directed bench for display_scan_ctrl with CLK_HZ=8, REFRESH_HZ=2 (DIV=4).
// A cycle model tracks the scan slot and the conversion countdown; expected
// digits are queued when a LOAD is accepted and popped on the commit edge.
// Every cycle BUSY, DONE, AN and BCD are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

   localparam int VALUE_W = 14;
   localparam int DIV     = 4;
   localparam int CONV    = VALUE_W + 1;   // LOAD edge to COMMIT edge

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   display_scan_ctrl_if #(.VALUE_W(VALUE_W)) bus ();

   display_scan_ctrl #(
      .CLK_HZ     (8),
      .REFRESH_HZ (2),
      .VALUE_W    (VALUE_W),
      .LZ_BLANK   (1'b1)
   ) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int    errors    = 0;
   int    checks    = 0;
   int    done_seen = 0;
   string phase     = "reset";

   // ---- reference model -----------------------------------------------------
   int          m_tick = 0;
   int          m_idx  = 0;
   int          m_cnt  = 0;
   logic [3:0]  m_dig [4];
   logic [3:0]  m_an  = 4'b1110;
   logic [3:0]  m_bcd = 4'd0;
   logic [15:0] sb_q [$];

   function automatic logic [15:0] to_bcd(input int v);
      int s;
      s = (v > 9999) ? 9999 : v;
      return {4'((s / 1000) % 10), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s.%s observed=%0h expected=%0h at %0t", phase, tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic        zero_above;
      logic [15:0] w;
      if (!rst_n) begin
         m_tick = 0;
         m_idx  = 0;
         m_cnt  = 0;
         for (int k = 0; k < 4; k++) m_dig[k] = 4'd0;
         m_an   = 4'b1110;
         m_bcd  = 4'd0;
         sb_q.delete();
      end else begin
         if (m_tick == DIV - 1) begin
            m_tick = 0;
            m_idx  = (m_idx + 1) % 4;
            m_bcd  = m_dig[m_idx];
            zero_above = 1'b1;
            for (int k = 3; k >= m_idx; k--) if (m_dig[k] != 4'd0) zero_above = 1'b0;
            m_an = ((m_idx != 0) && zero_above) ? 4'b1111 : ~(4'b0001 << m_idx);
         end else begin
            m_tick++;
         end
         if (m_cnt != 0) begin
            m_cnt--;
            if (m_cnt == 0 && sb_q.size() > 0) begin
               w = sb_q.pop_front();
               m_dig[0] = w[3:0];
               m_dig[1] = w[7:4];
               m_dig[2] = w[11:8];
               m_dig[3] = w[15:12];
            end
         end else if (bus.LOAD) begin
            m_cnt = CONV;
            sb_q.push_back(to_bcd(int'(bus.VALUE)));
         end
      end
   endtask

   // One clock: model follows the rising edge, DUT is compared on the falling.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (bus.DONE === 1'b1) done_seen++;
      check("busy", 32'(bus.BUSY), 32'(m_cnt != 0));
      check("done", 32'(bus.DONE), 32'(m_cnt == 1));
      check("an",   32'(bus.AN),   32'(m_an));
      check("bcd",  32'(bus.BCD),  32'(m_bcd));
   endtask

   task automatic do_load(input int v);
      bus.VALUE = VALUE_W'(v);
      bus.LOAD  = 1'b1;
      cycle();
      bus.LOAD  = 1'b0;
   endtask

   // Long enough to finish a conversion and show every slot twice.
   task automatic settle();
      repeat (CONV + 2 * 4 * DIV) cycle();
   endtask

   initial begin
      int done_before;
      for (int k = 0; k < 4; k++) m_dig[k] = 4'd0;
      bus.VALUE = '0;
      bus.LOAD  = 1'b0;

      phase = "reset";
      repeat (3) cycle();
      rst_n = 1'b1;
      phase = "idle_scan";
      repeat (4 * DIV + 4) cycle();

      phase = "v1234";
      do_load(1234);
      settle();

      phase = "v12000_sat";
      do_load(12000);
      settle();

      phase = "v7_blank";
      do_load(7);
      settle();

      phase = "v100_blank";
      do_load(100);
      settle();

      phase = "v5678_ignore42";
      done_before = done_seen;
      do_load(5678);
      repeat (4) cycle();
      do_load(42);
      settle();
      check("done_count", 32'(done_seen - done_before), 32'd1);

      phase = "load_in_commit";
      done_before = done_seen;
      do_load(321);
      repeat (CONV - 1) cycle();
      do_load(55);
      settle();
      check("done_count", 32'(done_seen - done_before), 32'd1);

      phase = "reset_mid";
      done_before = done_seen;
      do_load(9999);
      repeat (5) cycle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      repeat (CONV + 4) cycle();
      check("done_count", 32'(done_seen - done_before), 32'd0);

      phase = "v1_after_reset";
      done_before = done_seen;
      do_load(1);
      settle();
      check("done_count", 32'(done_seen - done_before), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
